// File: rtl/rom_arb_pkg.sv
// Shared types and default sizes for the ROM read arbiter.
package rom_arb_pkg;

  typedef enum logic {StIdle, StRead} state_e;

  localparam int unsigned DefAddrWidth = 8;
  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefNumReq    = 4;

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester and ROM-side signals of the ROM read arbiter, grouped as one bus.
interface rom_arbiter_if import rom_arb_pkg::*; #(
  parameter int unsigned ADDR_width = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned NUM_REQ    = DefNumReq
);

  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ*ADDR_width-1:0] addr_i;
  logic [NUM_REQ-1:0]            gnt_o;
  logic [DATA_WIDTH-1:0]         rdata_o;
  logic [NUM_REQ-1:0]            rvalid_o;
  logic                          busy_o;
  logic [ADDR_width-1:0]         rom_addr_o;
  logic [DATA_WIDTH-1:0]         rom_data_i;

  modport slave (
    input  req_i, addr_i, rom_data_i,
    output gnt_o, rdata_o, rvalid_o, busy_o, rom_addr_o
  );

  modport master (
    output req_i, addr_i, rom_data_i,
    input  gnt_o, rdata_o, rvalid_o, busy_o, rom_addr_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational one-hot winner select; round-robin from ptr_i, or lowest index first
// when ROM_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter import rom_arb_pkg::*; #(
  parameter int unsigned NumReq = DefNumReq,
  localparam int unsigned PtrW  = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
`ifndef ROM_ARB_FIXED_PRIO_EN
  input  logic [PtrW-1:0]   ptr_i,
`endif
  output logic [NumReq-1:0] gnt_o
);

  logic [PtrW:0]   sum;
  logic [PtrW-1:0] k;
  logic            found;

  always_comb begin
    gnt_o = '0;
    sum   = '0;
    k     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      k = PtrW'(i);
`else
      // ptr_i + i stays below 2*NumReq, so one subtraction is enough to wrap.
      sum = {1'b0, ptr_i} + (PtrW+1)'(i);
      if (sum >= (PtrW+1)'(NumReq)) sum = sum - (PtrW+1)'(NumReq);
      k = sum[PtrW-1:0];
`endif
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Two-state arbiter sharing one combinational ROM among NUM_REQ requesters.
// Define ROM_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module rom_arbiter import rom_arb_pkg::*; #(
  parameter int unsigned ADDR_width = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned NUM_REQ    = DefNumReq
) (
  input logic          clk,
  input logic          rst_n,
  rom_arbiter_if.slave bus
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  state_e                state_q;
  logic [NUM_REQ-1:0]    gnt_q, rvalid_q, win_gnt;
  logic [ADDR_width-1:0] rom_addr_q, win_addr;
  logic [DATA_WIDTH-1:0] rdata_q;

`ifndef ROM_ARB_FIXED_PRIO_EN
  logic [PtrW-1:0] ptr_q, ptr_d;
`endif

  rr_arbiter #(
    .NumReq(NUM_REQ)
  ) u_arb (
    .req_i(bus.req_i),
`ifndef ROM_ARB_FIXED_PRIO_EN
    .ptr_i(ptr_q),
`endif
    .gnt_o(win_gnt)
  );

  always_comb begin
    win_addr = '0;
`ifndef ROM_ARB_FIXED_PRIO_EN
    ptr_d = ptr_q;
`endif
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (win_gnt[k]) begin
        win_addr = bus.addr_i[k*ADDR_width +: ADDR_width];
`ifndef ROM_ARB_FIXED_PRIO_EN
        ptr_d = (k == NUM_REQ - 1) ? '0 : PtrW'(k + 1);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      rom_addr_q <= '0;
`ifndef ROM_ARB_FIXED_PRIO_EN
      ptr_q      <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          rvalid_q <= '0;
          gnt_q    <= win_gnt;
          if (|win_gnt) begin
            rom_addr_q <= win_addr;
            state_q    <= StRead;
`ifndef ROM_ARB_FIXED_PRIO_EN
            ptr_q      <= ptr_d;
`endif
          end
        end
        StRead: begin
          // Requests are ignored here; the grant register remembers who is served.
          rdata_q  <= bus.rom_data_i;
          rvalid_q <= gnt_q;
          gnt_q    <= '0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gnt_o      = gnt_q;
  assign bus.rvalid_o   = rvalid_q;
  assign bus.rdata_o    = rdata_q;
  assign bus.rom_addr_o = rom_addr_q;
  assign bus.busy_o     = (state_q == StRead);

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: the driver predicts grants/reads from the arbitration
// rules, a monitor pops and compares whenever the DUT pulses gnt_o or rvalid_o.
module tb_rom_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;

  typedef struct {
    int         cyc;
    int         who;
    logic [7:0] val;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rom_arbiter_if #(.ADDR_width(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  assign bus.rom_data_i = bus.rom_addr_o + 8'd1;

  rom_arbiter #(
    .ADDR_width(AW),
    .DATA_WIDTH(DW),
    .NUM_REQ   (NR)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_g[$];
  exp_t exp_r[$];

  int         m_p    = 0;
  bit         m_read = 1'b0;
  bit         pend[NR];
  logic [7:0] paddr[NR];
  bit         sweeping = 1'b0;
  int         sweep_n  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] r);
`ifdef ROM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NR; i++) if (r[i]) return i;
`else
    for (int i = 0; i < NR; i++) if (r[(m_p + i) % NR]) return (m_p + i) % NR;
`endif
    return -1;
  endfunction

  // Drive the requesters for the coming edge and predict what that edge produces.
  task automatic tick();
    logic [NR-1:0] r;
    int w;
    for (int k = 0; k < NR; k++) begin
      r[k] = pend[k];
      bus.addr_i[k*AW +: AW] = paddr[k];
    end
    bus.req_i = r;
    if (m_read) begin
      m_read = 1'b0;
    end else if (r != '0) begin
      w = pick(r);
      exp_g.push_back('{cyc + 1, w, paddr[w]});
      exp_r.push_back('{cyc + 2, w, paddr[w] + 8'd1});
      m_p     = (w + 1) % NR;
      m_read  = 1'b1;
      pend[w] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_pend();
    for (int k = 0; k < NR; k++) pend[k] = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt_o), 0);
    chk({tag, "_rvalid"}, 32'(bus.rvalid_o), 0);
    chk({tag, "_busy"}, 32'(bus.busy_o), 0);
    chk({tag, "_rdata"}, 32'(bus.rdata_o), 0);
    chk({tag, "_rom_addr"}, 32'(bus.rom_addr_o), 0);
  endtask

  // Monitor
  initial begin
    logic [7:0] last_d, last_a;
    exp_t e;
    bit exp_busy;
    last_d = '0;
    last_a = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        last_d = '0;
        last_a = '0;
      end else begin
        if (bus.gnt_o != '0) begin
          if (exp_g.size() == 0) begin
            chk("gnt_unexpected", 32'(bus.gnt_o), 0);
          end else begin
            e = exp_g.pop_front();
            chk("gnt_vec", 32'(bus.gnt_o), 32'(1) << e.who);
            chk("gnt_cycle", cyc, e.cyc);
            chk("rom_addr", 32'(bus.rom_addr_o), 32'(e.val));
            last_a = e.val;
          end
        end else if (exp_g.size() != 0 && exp_g[0].cyc <= cyc) begin
          e = exp_g.pop_front();
          chk("gnt_missing", 0, 32'(1) << e.who);
        end
        if (bus.rvalid_o != '0) begin
          if (exp_r.size() == 0) begin
            chk("rvalid_unexpected", 32'(bus.rvalid_o), 0);
          end else begin
            e = exp_r.pop_front();
            chk("rvalid_vec", 32'(bus.rvalid_o), 32'(1) << e.who);
            chk("rvalid_cycle", cyc, e.cyc);
            chk("rdata", 32'(bus.rdata_o), 32'(e.val));
            last_d = e.val;
            if (sweeping && e.who == 2) sweep_n++;
          end
        end else if (exp_r.size() != 0 && exp_r[0].cyc <= cyc) begin
          e = exp_r.pop_front();
          chk("rvalid_missing", 0, 32'(1) << e.who);
        end
        chk("rdata_hold", 32'(bus.rdata_o), 32'(last_d));
        chk("rom_addr_hold", 32'(bus.rom_addr_o), 32'(last_a));
        exp_busy = (exp_r.size() != 0) && (exp_r[0].cyc == cyc + 1);
        chk("busy", 32'(bus.busy_o), 32'(exp_busy));
      end
    end
  end

  initial begin
    bus.req_i  = '0;
    bus.addr_i = '0;
    for (int k = 0; k < NR; k++) begin
      pend[k]  = 1'b0;
      paddr[k] = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Contention: all four held
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < NR; k++) begin
        pend[k]  = 1'b1;
        paddr[k] = 8'(16 * k + i);
      end
      tick();
    end
    clear_pend();
    ticks(2);

    // Single request
    pend[1] = 1'b1; paddr[1] = 8'h80;
    ticks(3);

    // Pointer wrap 3 -> 0, then pointer at 1
    pend[2] = 1'b1; paddr[2] = 8'h11;
    ticks(2);
    pend[0] = 1'b1; paddr[0] = 8'h20;
    pend[3] = 1'b1; paddr[3] = 8'h30;
    ticks(4);
    pend[0] = 1'b1; paddr[0] = 8'h21;
    pend[1] = 1'b1; paddr[1] = 8'h41;
    ticks(5);

    // Boundary address
    pend[0] = 1'b1; paddr[0] = 8'hFF;
    ticks(3);

    // Reset in the READ cycle
    pend[1] = 1'b1; paddr[1] = 8'h33;
    tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midread");
    void'(exp_r.pop_back());
    m_read = 1'b0;
    m_p    = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(3);
    pend[3] = 1'b1; paddr[3] = 8'h5A;
    ticks(3);

    // Sequential sweep by requester 2
    sweeping = 1'b1;
    for (int a = 128; a < 256; a++) begin
      pend[2] = 1'b1; paddr[2] = 8'(a);
      ticks(2);
    end
    tick();
    sweeping = 1'b0;
    chk("sweep_count", sweep_n, 128);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NR; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k]  = 1'b1;
          paddr[k] = 8'($urandom);
        end
      end
      tick();
    end
    clear_pend();
    ticks(4);
    chk("gnt_queue_drained", exp_g.size(), 0);
    chk("rvalid_queue_drained", exp_r.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
